// File: rtl/prog_mem_ctrl.sv
// prog_mem_ctrl: loads a UART byte stream into the single-port program memory
// as packed instruction words, then hands the memory port to the CPU fetch stage.
// Optional build macro: PROG_MEM_CHECKSUM_EN enables a running XOR checksum of
// the accepted bytes on o_checksum; otherwise o_checksum is tied to zero.
module prog_mem_ctrl #(
    parameter int unsigned          RAM_WIDTH  = 16,
    parameter int unsigned          ADDR_WIDTH = 10,
    parameter logic [RAM_WIDTH-1:0] END_WORD   = '0
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  i_load_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic                  i_cpu_en,
    output logic                  o_cpu_stall,
    output logic                  o_cpu_data_valid,
    output logic [ADDR_WIDTH-1:0] o_addra,
    output logic [RAM_WIDTH-1:0]  o_dina,
    output logic                  o_wea,
    output logic                  o_ena,
    output logic                  o_regcea,
    output logic                  o_load_done,
    output logic                  o_full,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic [7:0]            o_checksum
);

    localparam int unsigned NBYTES = (RAM_WIDTH + 7) / 8;
    localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [BCW-1:0]          byte_cnt;
    logic [RAM_WIDTH-1:0]    word;
    logic                    valid_s1, valid_s2;
    logic                    accept, last_byte, at_top, write_end, load_start_ok;

    assign accept        = (state == LOAD) && o_rx_ready && i_rx_valid;
    assign last_byte     = (byte_cnt == LAST_BYTE);
    assign at_top        = (wr_ptr == {ADDR_WIDTH{1'b1}});
    assign write_end     = (word == END_WORD) || at_top;
    assign load_start_ok = i_load_start && ((state == IDLE) || (state == RUN));
    assign o_cpu_data_valid = valid_s2;

    // State register
    always_ff @(posedge clka) begin
        if (rsta) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state decode and combinational memory port drive
    always_comb begin
        next_state = state;
        o_ena      = 1'b0;
        o_wea      = 1'b0;
        o_addra    = '0;
        o_dina     = '0;
        case (state)
            IDLE:  if (i_load_start) next_state = LOAD;
            LOAD:  if (accept && last_byte) next_state = WRITE;
            WRITE: begin
                o_ena      = 1'b1;
                o_wea      = 1'b1;
                o_addra    = wr_ptr;
                o_dina     = word;
                next_state = write_end ? RUN : LOAD;
            end
            RUN: begin
                o_ena   = i_cpu_en;
                o_addra = i_cpu_addr;
                if (i_load_start) next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered status outputs, fetch-valid pipeline, load datapath
    always_ff @(posedge clka) begin
        if (rsta) begin
            o_rx_ready   <= 1'b0;
            o_cpu_stall  <= 1'b1;
            o_load_done  <= 1'b0;
            o_regcea     <= 1'b0;
            o_full       <= 1'b0;
            o_word_count <= '0;
            valid_s1     <= 1'b0;
            valid_s2     <= 1'b0;
            wr_ptr       <= '0;
            byte_cnt     <= '0;
            word         <= '0;
        end else begin
            o_rx_ready  <= (next_state == LOAD);
            o_cpu_stall <= (next_state != RUN);
            o_load_done <= (next_state == RUN);
            o_regcea    <= (next_state == RUN);
            // a fetch issued on the cycle RUN is left never reports valid
            valid_s1    <= (state == RUN) && i_cpu_en && (next_state == RUN);
            valid_s2    <= valid_s1 && (next_state == RUN);
            if (load_start_ok) begin
                wr_ptr       <= '0;
                byte_cnt     <= '0;
                word         <= '0;
                o_word_count <= '0;
                o_full       <= 1'b0;
            end else begin
                if (accept) begin
                    word     <= RAM_WIDTH'({word, i_rx_data});
                    byte_cnt <= last_byte ? '0 : byte_cnt + BCW'(1);
                end
                if (state == WRITE) begin
                    o_word_count <= o_word_count + (ADDR_WIDTH + 1)'(1);
                    if (at_top)          o_full <= 1'b1;
                    else if (!write_end) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                end
            end
        end
    end

`ifdef PROG_MEM_CHECKSUM_EN
    logic [7:0] checksum;
    assign o_checksum = checksum;

    // Running XOR of every byte accepted since the last load start
    always_ff @(posedge clka) begin
        if (rsta || load_start_ok) checksum <= 8'h00;
        else if (accept)           checksum <= checksum ^ i_rx_data;
    end
`else
    assign o_checksum = 8'h00;
`endif

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Self-checking bench for prog_mem_ctrl (16-bit words, 8-entry memory).
module tb_prog_mem_ctrl;

    localparam int unsigned RW = 16;
    localparam int unsigned AW = 3;

    logic          clka = 1'b0;
    logic          rsta;
    logic          i_load_start;
    logic [7:0]    i_rx_data;
    logic          i_rx_valid;
    logic          o_rx_ready;
    logic [AW-1:0] i_cpu_addr;
    logic          i_cpu_en;
    logic          o_cpu_stall;
    logic          o_cpu_data_valid;
    logic [AW-1:0] o_addra;
    logic [RW-1:0] o_dina;
    logic          o_wea;
    logic          o_ena;
    logic          o_regcea;
    logic          o_load_done;
    logic          o_full;
    logic [AW:0]   o_word_count;
    logic [7:0]    o_checksum;

    prog_mem_ctrl #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .END_WORD('0)) dut (
        .clka(clka), .rsta(rsta), .i_load_start(i_load_start),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .i_cpu_addr(i_cpu_addr), .i_cpu_en(i_cpu_en), .o_cpu_stall(o_cpu_stall),
        .o_cpu_data_valid(o_cpu_data_valid), .o_addra(o_addra), .o_dina(o_dina),
        .o_wea(o_wea), .o_ena(o_ena), .o_regcea(o_regcea),
        .o_load_done(o_load_done), .o_full(o_full),
        .o_word_count(o_word_count), .o_checksum(o_checksum)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic          st, rv;
        logic [7:0]    rd;
        logic          ce;
        logic [AW-1:0] ca;
        logic          e_rdy, e_ena, e_wea;
        logic [AW-1:0] e_addr;
        logic [RW-1:0] e_din;
        logic          e_stall, e_done, e_regce, e_dv;
        logic [AW:0]   e_wc;
    } vec_t;

    int            n_chk = 0;
    int            n_err = 0;
    int            rdy_viol = 0;
    logic [AW-1:0] wq_a[$];
    logic [RW-1:0] wq_d[$];
    logic [7:0]    csum_model;

    // Log every memory write as seen mid-cycle
    always @(negedge clka) begin
        if (o_wea) begin
            wq_a.push_back(o_addra);
            wq_d.push_back(o_dina);
            if (o_rx_ready) rdy_viol++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n = 0;
        int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            i_rx_valid = 1'b0;
            @(negedge clka);
        end
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        while (!o_rx_ready && n < 20) begin
            @(negedge clka);
            n++;
        end
        if (!o_rx_ready) chk("rx_ready timeout", 32'(o_rx_ready), 32'd1);
        else csum_model = csum_model ^ b;
        @(negedge clka);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [RW-1:0] w, input int max_gap);
        send_byte(w[15:8], max_gap);
        send_byte(w[7:0], max_gap);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_load_done && n < 50) begin
            @(negedge clka);
            n++;
        end
        chk("load_done wait", 32'(o_load_done), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clka);
        i_load_start = 1'b1;
        @(negedge clka);
        i_load_start = 1'b0;
        csum_model = 8'h00;
    endtask

    function automatic logic [7:0] exp_csum(input logic [7:0] m);
`ifdef PROG_MEM_CHECKSUM_EN
        return m;
`else
        return 8'h00 & m;
`endif
    endfunction

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1,0,8'h00,0,0, 0,0,0,0,16'h0000, 1,0,0,0,0};
        vecs[1]  = '{0,1,8'h12,0,0, 1,0,0,0,16'h0000, 1,0,0,0,0};
        vecs[2]  = '{0,1,8'h34,0,0, 1,0,0,0,16'h0000, 1,0,0,0,0};
        vecs[3]  = '{0,1,8'h56,0,0, 0,1,1,0,16'h1234, 1,0,0,0,0};
        vecs[4]  = '{0,1,8'h56,0,0, 1,0,0,0,16'h0000, 1,0,0,0,1};
        vecs[5]  = '{0,1,8'h78,0,0, 1,0,0,0,16'h0000, 1,0,0,0,1};
        vecs[6]  = '{0,0,8'h00,0,0, 0,1,1,1,16'h5678, 1,0,0,0,1};
        vecs[7]  = '{0,1,8'h00,0,0, 1,0,0,0,16'h0000, 1,0,0,0,2};
        vecs[8]  = '{0,1,8'h00,0,0, 1,0,0,0,16'h0000, 1,0,0,0,2};
        vecs[9]  = '{0,0,8'h00,0,0, 0,1,1,2,16'h0000, 1,0,0,0,2};
        vecs[10] = '{0,0,8'h00,1,0, 0,1,0,0,16'h0000, 0,1,1,0,3};
        vecs[11] = '{0,0,8'h00,1,1, 0,1,0,1,16'h0000, 0,1,1,0,3};
        vecs[12] = '{0,0,8'h00,1,2, 0,1,0,2,16'h0000, 0,1,1,1,3};
        vecs[13] = '{0,0,8'h00,0,5, 0,0,0,5,16'h0000, 0,1,1,1,3};
        vecs[14] = '{0,0,8'h00,0,0, 0,0,0,0,16'h0000, 0,1,1,1,3};
        vecs[15] = '{0,0,8'h00,0,0, 0,0,0,0,16'h0000, 0,1,1,0,3};

        rsta = 1'b1; i_load_start = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0;
        i_cpu_addr = '0; i_cpu_en = 1'b0; csum_model = 8'h00;
        repeat (3) @(posedge clka);
        @(negedge clka);
        rsta = 1'b0;

        // reset state
        chk("rst ena", 32'(o_ena), 0);
        chk("rst rx_ready", 32'(o_rx_ready), 0);
        chk("rst stall", 32'(o_cpu_stall), 1);
        chk("rst load_done", 32'(o_load_done), 0);
        chk("rst word_count", 32'(o_word_count), 0);
        chk("rst checksum", 32'(o_checksum), 0);

        // basic load of 1234,5678,0000 followed by three fetches
        for (int i = 0; i < 16; i++) begin
            i_load_start = vecs[i].st; i_rx_valid = vecs[i].rv; i_rx_data = vecs[i].rd;
            i_cpu_en = vecs[i].ce; i_cpu_addr = vecs[i].ca;
            #1;
            chk($sformatf("row%0d rx_ready", i), 32'(o_rx_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("row%0d ena", i), 32'(o_ena), 32'(vecs[i].e_ena));
            chk($sformatf("row%0d wea", i), 32'(o_wea), 32'(vecs[i].e_wea));
            chk($sformatf("row%0d addra", i), 32'(o_addra), 32'(vecs[i].e_addr));
            chk($sformatf("row%0d dina", i), 32'(o_dina), 32'(vecs[i].e_din));
            chk($sformatf("row%0d stall", i), 32'(o_cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("row%0d load_done", i), 32'(o_load_done), 32'(vecs[i].e_done));
            chk($sformatf("row%0d regcea", i), 32'(o_regcea), 32'(vecs[i].e_regce));
            chk($sformatf("row%0d data_valid", i), 32'(o_cpu_data_valid), 32'(vecs[i].e_dv));
            chk($sformatf("row%0d word_count", i), 32'(o_word_count), 32'(vecs[i].e_wc));
            chk($sformatf("row%0d full", i), 32'(o_full), 0);
            @(negedge clka);
        end
        i_rx_valid = 1'b0; i_cpu_en = 1'b0; i_cpu_addr = '0;
        chk("basic nwrites", 32'(wq_a.size()), 3);
        chk("basic checksum", 32'(o_checksum), 32'(exp_csum(8'h08)));

        // reload coinciding with a fetch: load wins, fetch valid flushed
        wq_a.delete(); wq_d.delete();
        i_load_start = 1'b1; i_cpu_en = 1'b1; i_cpu_addr = 3'd4;
        @(negedge clka);
        i_load_start = 1'b0; i_cpu_en = 1'b0;
        csum_model = 8'h00;
        chk("reload load_done", 32'(o_load_done), 0);
        chk("reload rx_ready", 32'(o_rx_ready), 1);
        chk("reload word_count", 32'(o_word_count), 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reload dv%0d", k), 32'(o_cpu_data_valid), 0);
            @(negedge clka);
        end

        // backpressured 4-word load into the reloaded memory
        send_word(16'hA1B2, 2);
        send_word(16'hC3D4, 2);
        send_word(16'hE5F6, 2);
        send_word(16'h0000, 2);
        wait_done();
        chk("bp nwrites", 32'(wq_a.size()), 4);
        for (int k = 0; k < 4; k++) begin
            if (wq_a.size() > k) begin
                chk($sformatf("bp addr%0d", k), 32'(wq_a[k]), 32'(k));
            end
        end
        if (wq_d.size() >= 4) begin
            chk("bp data0", 32'(wq_d[0]), 32'h A1B2);
            chk("bp data1", 32'(wq_d[1]), 32'h C3D4);
            chk("bp data2", 32'(wq_d[2]), 32'h E5F6);
            chk("bp data3", 32'(wq_d[3]), 32'h 0000);
        end
        chk("bp word_count", 32'(o_word_count), 4);
        chk("bp full", 32'(o_full), 0);
        chk("bp ready in write", 32'(rdy_viol), 0);
        chk("bp checksum", 32'(o_checksum), 32'(exp_csum(csum_model)));

        // overflow: 8 nonzero words fill the memory
        wq_a.delete(); wq_d.delete();
        pulse_start();
        for (int k = 0; k < 8; k++) send_word(16'(16'h0101 * (k + 1)), 0);
        wait_done();
        chk("ovf nwrites", 32'(wq_a.size()), 8);
        if (wq_a.size() == 8) begin
            chk("ovf last addr", 32'(wq_a[7]), 7);
            chk("ovf last data", 32'(wq_d[7]), 32'h0808);
        end
        chk("ovf full", 32'(o_full), 1);
        chk("ovf word_count", 32'(o_word_count), 8);
        i_rx_valid = 1'b1; i_rx_data = 8'h55;
        repeat (5) @(negedge clka);
        chk("ovf rx_ready after", 32'(o_rx_ready), 0);
        i_rx_valid = 1'b0;
        chk("ovf no extra write", 32'(wq_a.size()), 8);

        // reset after one byte of a word: no write, back to IDLE
        wq_a.delete(); wq_d.delete();
        pulse_start();
        send_byte(8'hAA, 0);
        rsta = 1'b1;
        @(negedge clka);
        rsta = 1'b0;
        repeat (3) @(negedge clka);
        chk("midrst nwrites", 32'(wq_a.size()), 0);
        chk("midrst rx_ready", 32'(o_rx_ready), 0);
        chk("midrst stall", 32'(o_cpu_stall), 1);
        chk("midrst ena", 32'(o_ena), 0);
        chk("midrst full", 32'(o_full), 0);
        chk("midrst word_count", 32'(o_word_count), 0);

        // a fresh load after the reset packs cleanly from address 0
        pulse_start();
        send_word(16'hBEEF, 0);
        send_word(16'h0000, 0);
        wait_done();
        chk("postrst nwrites", 32'(wq_a.size()), 2);
        if (wq_a.size() >= 1) begin
            chk("postrst addr0", 32'(wq_a[0]), 0);
            chk("postrst data0", 32'(wq_d[0]), 32'hBEEF);
        end
        chk("postrst checksum", 32'(o_checksum), 32'(exp_csum(8'hBE ^ 8'hEF)));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/prog_mem_ctrl.md
# prog_mem_ctrl

Sequencing controller for the program memory. After a start pulse it accepts a byte stream from the UART receiver and packs it into RAM_WIDTH-bit instruction words. It writes those words sequentially into the single-port program memory from address 0, then hands the memory port to the CPU fetch stage. It drives every control pin of the memory (address, data, write enable, enable, output-register enable) and tracks the memory's 2-cycle read latency for the CPU.

## Interface
- RAM_WIDTH, 16: instruction width; must equal the memory's RAM_WIDTH.
- ADDR_WIDTH, 10: memory address width (RAM_DEPTH = 2**ADDR_WIDTH).
- END_WORD, 0: word value that terminates a load (HLT opcode).
- Derived localparam NBYTES = ceil(RAM_WIDTH/8).

Ports:
- clka  in  1  clock
- rsta  in  1  reset, synchronous, active-high
- i_load_start  in  1  single-cycle pulse; starts a program load
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  byte valid
- o_rx_ready  out  1  controller accepts byte
- i_cpu_addr  in  ADDR_WIDTH  fetch address (PC)
- i_cpu_en  in  1  fetch request
- o_cpu_stall  out  1  CPU must hold; port not granted
- o_cpu_data_valid  out  1  memory douta holds the fetch issued 2 cycles earlier
- o_addra  out  ADDR_WIDTH  memory address
- o_dina  out  RAM_WIDTH  memory write data
- o_wea  out  1  memory write enable
- o_ena  out  1  memory enable
- o_regcea  out  1  memory output register enable
- o_load_done  out  1  level; load finished, CPU running
- o_full  out  1  sticky; load ended by reaching the last address
- o_word_count  out  ADDR_WIDTH+1  words written in the last or current load
- o_checksum  out  8  see Configuration

## Operation
- States: IDLE, LOAD, WRITE, RUN. Reset enters IDLE.
- IDLE:
  - o_ena=0, o_cpu_stall=1.
  - i_load_start moves to LOAD; wr_ptr, byte counter, o_word_count, o_full and checksum all clear.
- LOAD:
  - o_rx_ready=1.
  - Each accepted byte (i_rx_valid & o_rx_ready at a clock edge) shifts into the word register MSB-first: word = {word[RAM_WIDTH-9:0], byte}. If RAM_WIDTH is not a multiple of 8, only the low RAM_WIDTH bits of the packed result are kept.
  - On the NBYTES-th byte, go to WRITE.
- WRITE (exactly 1 cycle):
  - o_rx_ready=0; o_ena=1, o_wea=1, o_addra=wr_ptr, o_dina=word.
  - o_word_count increments.
  - If word==END_WORD, or wr_ptr==2**ADDR_WIDTH-1 (which also sets o_full), go to RUN.
  - Otherwise wr_ptr+1 and return to LOAD.
  - wr_ptr never wraps.
- RUN:
  - o_load_done=1, o_cpu_stall=0, o_rx_ready=0.
  - o_addra=i_cpu_addr, o_ena=i_cpu_en, o_wea=0, o_dina=0, o_regcea=1.
  - i_load_start returns to LOAD and restarts at address 0 (reload). o_load_done drops the next cycle.
- In LOAD/WRITE: CPU requests are ignored, o_cpu_stall=1, o_regcea=0.
- i_load_start is ignored outside IDLE and RUN.
- Bytes presented outside LOAD are not accepted (ready=0) and are not dropped by the controller.

## Timing
- Reset (rsta high at an edge): all outputs 0, except o_cpu_stall=1. State becomes IDLE. The valid pipeline, counters and flags clear. Memory contents are untouched.
- Reset mid-load: the partial word is discarded and no write is issued.
- Byte-to-write latency: the WRITE cycle immediately follows the edge that accepted the last byte of a word. Throughput is at most one word per NBYTES+1 cycles.
- Fetch latency:
  - o_cpu_data_valid is a 2-stage shift of (state==RUN & i_cpu_en).
  - It is high exactly 2 cycles after the request, matching the memory's HIGH_PERFORMANCE mode.
  - The pipeline flushes to 0 the cycle the state leaves RUN.
- i_load_start coinciding with i_cpu_en in RUN: the load wins. The fetch is issued that cycle, but its valid is flushed.
- All outputs are registered, except o_addra/o_ena/o_dina/o_wea. These four are combinational from the state register plus the CPU inputs in RUN, or from registered word/wr_ptr in WRITE.

## Configuration
- PROG_MEM_CHECKSUM_EN defined:
  - o_checksum is the running XOR of every byte accepted since the last load start.
  - It is cleared on load start and on reset, and is stable once o_load_done is set.
- PROG_MEM_CHECKSUM_EN undefined: o_checksum is tied to 8'h00 and no checksum logic is built.

## Test plan
- Reset value check: after reset, o_ena=0, o_rx_ready=0, o_cpu_stall=1, o_load_done=0, o_word_count=0.
- Basic load: start pulse, then bytes 12,34,56,78,00,00 (RAM_WIDTH=16).
  - Writes 0x1234@0, 0x5678@1, 0x0000@2; each write is a 1-cycle wea pulse.
  - Then o_load_done=1, o_word_count=3, o_full=0.
  - With the macro defined, o_checksum=0x08.
- Backpressure: i_rx_valid toggled randomly during a 4-word load.
  - Every byte is taken exactly once; o_rx_ready=0 in each WRITE cycle.
- Overflow: ADDR_WIDTH=3, send 8 nonzero words.
  - Last write lands at address 7; o_full=1, o_word_count=8; no write to address 0 afterwards.
- Fetch: after load, i_cpu_en=1 with addr 0,1,2 on consecutive cycles.
  - o_cpu_data_valid is high on cycles 2,3,4; o_addra follows i_cpu_addr; o_wea stays 0.
- Reload/reset mid-operation:
  - In RUN, start pulse together with i_cpu_en: no valid pulse 2 cycles later; the new load starts at address 0.
  - rsta after 1 byte of a word: no write occurs, and state is IDLE.
